// File: rtl/bambu_mem_initiator_port_if.sv
// Request/response channel and off-chip memory bus bundled for the memory initiator port.
// The master modport is the initiator's own view of these signals; the slave modport is the view of whatever connects to it.
interface bambu_mem_initiator_port_if #(
  parameter int unsigned BITSIZE_addr = 7,
  parameter int unsigned BITSIZE_data = 8,
  parameter int unsigned BITSIZE_size = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [BITSIZE_addr-1:0] req_addr;
  logic [BITSIZE_data-1:0] req_wdata;
  logic [BITSIZE_size-1:0] req_size;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [BITSIZE_data-1:0] rsp_rdata;
  logic                    rsp_err;
  logic                    Mout_oe_ram;
  logic                    Mout_we_ram;
  logic [BITSIZE_addr-1:0] Mout_addr_ram;
  logic [BITSIZE_data-1:0] Mout_Wdata_ram;
  logic [BITSIZE_size-1:0] Mout_data_ram_size;
  logic                    M_DataRdy;
  logic [BITSIZE_data-1:0] M_Rdata_ram;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready, M_DataRdy, M_Rdata_ram,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready, M_DataRdy, M_Rdata_ram,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
  );
endinterface

// File: rtl/bambu_mem_initiator_port.sv
// Memory bus initiator: turns valid/ready requests into single oe/we bus cycles,
// waits for M_DataRdy (with timeout) and returns a held response.
module bambu_mem_initiator_port #(
  parameter int unsigned BITSIZE_addr   = 7,
  parameter int unsigned BITSIZE_data   = 8,
  parameter int unsigned BITSIZE_size   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic clock,
  input logic reset,
  bambu_mem_initiator_port_if.master bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t                  state, state_n;
  logic                    we_q, we_n;
  logic [BITSIZE_addr-1:0] addr_q, addr_n;
  logic [BITSIZE_data-1:0] wdata_q, wdata_n;
  logic [BITSIZE_size-1:0] size_q, size_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [BITSIZE_data-1:0] rdata_q, rdata_n;
  logic                    err_q, err_n;
  logic                    size_ok_c;

  // Lane mask keeping only bits below the access size
  function automatic logic [BITSIZE_data-1:0] size_mask(input logic [BITSIZE_size-1:0] sz);
    logic [BITSIZE_data-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BITSIZE_data); i++) m[i] = (i < int'(sz));
    return m;
  endfunction

  assign size_ok_c = (bus.req_size != '0) && (32'(bus.req_size) <= BITSIZE_data);

  // Next-state and transaction field update
  always_comb begin
    state_n = state;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    size_n  = size_q;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          we_n    = bus.req_we;
          addr_n  = bus.req_addr;
          size_n  = bus.req_size;
          wdata_n = bus.req_wdata & size_mask(bus.req_size);
          cnt_n   = '0;
          rdata_n = '0;
          if (size_ok_c) begin
            state_n = BUS;
            err_n   = 1'b0;
          end else begin
            state_n = RESP;
            err_n   = 1'b1;
          end
        end
      end
      BUS: begin
        // A completion in the expiry cycle still counts as a good transfer
        if (bus.M_DataRdy) begin
          state_n = GAP;
          err_n   = 1'b0;
          rdata_n = we_q ? '0 : (bus.M_Rdata_ram & size_mask(size_q));
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = GAP;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: state_n = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_n = IDLE;
          rdata_n = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, fields and registered outputs decoded from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      we_q                   <= 1'b0;
      addr_q                 <= '0;
      wdata_q                <= '0;
      size_q                 <= '0;
      cnt                    <= '0;
      rdata_q                <= '0;
      err_q                  <= 1'b0;
      bus.req_ready          <= 1'b1;
      bus.rsp_valid          <= 1'b0;
      bus.Mout_oe_ram        <= 1'b0;
      bus.Mout_we_ram        <= 1'b0;
      bus.Mout_addr_ram      <= '0;
      bus.Mout_Wdata_ram     <= '0;
      bus.Mout_data_ram_size <= '0;
    end else begin
      state                  <= state_n;
      we_q                   <= we_n;
      addr_q                 <= addr_n;
      wdata_q                <= wdata_n;
      size_q                 <= size_n;
      cnt                    <= cnt_n;
      rdata_q                <= rdata_n;
      err_q                  <= err_n;
      bus.req_ready          <= (state_n == IDLE);
      bus.rsp_valid          <= (state_n == RESP);
      bus.Mout_oe_ram        <= (state_n == BUS) && !we_n;
      bus.Mout_we_ram        <= (state_n == BUS) && we_n;
      bus.Mout_addr_ram      <= (state_n == BUS) ? addr_n  : '0;
      bus.Mout_Wdata_ram     <= (state_n == BUS && we_n) ? wdata_n : '0;
      bus.Mout_data_ram_size <= (state_n == BUS) ? size_n  : '0;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_bambu_mem_initiator_port.sv
// Bench for bambu_mem_initiator_port: memory responder (read delay configurable, write delay 1),
// vector table plus directed latency, timeout, backpressure and reset sequences.
module tb_bambu_mem_initiator_port;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bambu_mem_initiator_port_if #(.BITSIZE_addr(AW), .BITSIZE_data(DW), .BITSIZE_size(SW)) bus ();

  bambu_mem_initiator_port #(
    .BITSIZE_addr(AW), .BITSIZE_data(DW), .BITSIZE_size(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Responder: completes a read in its rd_delay-th enable cycle, a write in its first
  logic [DW-1:0] mem [128] = '{default: '0};
  int rd_delay = 2;
  int en_cnt   = 0;
  always @(posedge clock) begin
    if (bus.Mout_we_ram && bus.M_DataRdy) mem[bus.Mout_addr_ram] <= bus.Mout_Wdata_ram;
    if (bus.Mout_oe_ram || bus.Mout_we_ram) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end
  assign bus.M_DataRdy   = (bus.Mout_oe_ram && en_cnt == rd_delay - 1) || (bus.Mout_we_ram && en_cnt == 0);
  assign bus.M_Rdata_ram = bus.Mout_oe_ram ? mem[bus.Mout_addr_ram] : '0;

  // Bus monitor
  int oe_total = 0, we_total = 0, overlap = 0;
  logic [DW-1:0] last_wdata = '0;
  always @(negedge clock) begin
    if (bus.Mout_oe_ram) oe_total++;
    if (bus.Mout_we_ram) begin
      we_total++;
      last_wdata = bus.Mout_Wdata_ram;
    end
    if (bus.Mout_oe_ram && bus.Mout_we_ram) overlap++;
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] size;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_en;
    logic [DW-1:0] exp_wdata;
  } vec_t;
  vec_t vecs[8];

  int tests = 0, errors = 0;
  int oe_base = 0, we_base = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    int n = 0;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_size  = s;
    while (!bus.req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("req_accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    oe_base = oe_total;
    we_base = we_total;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.rsp_valid && cyc < 200);
    if (cyc >= 200) chk("rsp_wait_timeout", 0, 1);
  endtask

  task automatic check_rsp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_rdata"}, int'(bus.rsp_rdata), int'(e.rdata));
      chk({nm, "_err"}, int'(bus.rsp_err), int'(e.err));
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_size = '0; bus.rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 7'h05, 8'hA7, 4'd8, 8'h00, 3, 1, 8'hA7};
    vecs[1] = '{1'b0, 7'h05, 8'h00, 4'd8, 8'hA7, 4, 2, 8'h00};
    vecs[2] = '{1'b1, 7'h05, 8'hFF, 4'd4, 8'h00, 3, 1, 8'h0F};
    vecs[3] = '{1'b0, 7'h05, 8'h00, 4'd8, 8'h0F, 4, 2, 8'h00};
    vecs[4] = '{1'b1, 7'h10, 8'hA5, 4'd8, 8'h00, 3, 1, 8'hA5};
    vecs[5] = '{1'b0, 7'h10, 8'h00, 4'd3, 8'h05, 4, 2, 8'h00};
    vecs[6] = '{1'b0, 7'h10, 8'h00, 4'd1, 8'h01, 4, 2, 8'h00};
    vecs[7] = '{1'b1, 7'h11, 8'hFF, 4'd7, 8'h00, 3, 1, 8'h7F};

    // Reset state
    #12;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_oe_we", int'({bus.Mout_oe_ram, bus.Mout_we_ram}), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    @(negedge clock);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{vecs[i].exp_rdata, 1'b0});
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size);
      wait_rsp(cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
      chk($sformatf("v%0d_en_cycles", i), (oe_total - oe_base) + (we_total - we_base), vecs[i].exp_en);
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), int'(last_wdata), int'(vecs[i].exp_wdata));
      check_rsp($sformatf("v%0d", i));
      consume();
    end

    // Illegal sizes: no bus cycle, error response
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{8'h00, 1'b1});
      issue(1'(k), 7'h05, 8'h33, (k == 0) ? 4'd0 : 4'd9);
      @(negedge clock);
      @(negedge clock);
      chk($sformatf("ill%0d_valid", k), int'(bus.rsp_valid), 1);
      chk($sformatf("ill%0d_en_cycles", k), (oe_total - oe_base) + (we_total - we_base), 0);
      check_rsp($sformatf("ill%0d", k));
      consume();
    end

    // Timeout with no completion, then completion exactly at expiry
    rd_delay = 1000;
    sb.push_back('{8'h00, 1'b1});
    issue(1'b0, 7'h05, 8'h00, 4'd8);
    wait_rsp(cyc);
    chk("to_latency", cyc, 18);
    chk("to_oe_cycles", oe_total - oe_base, 16);
    check_rsp("to");
    consume();
    rd_delay = 16;
    sb.push_back('{8'h0F, 1'b0});
    issue(1'b0, 7'h05, 8'h00, 4'd8);
    wait_rsp(cyc);
    chk("edge_oe_cycles", oe_total - oe_base, 16);
    check_rsp("edge");
    consume();
    rd_delay = 2;

    // Response backpressure with a pending second request
    sb.push_back('{8'hA5, 1'b0});
    issue(1'b0, 7'h10, 8'h00, 4'd8);
    wait_rsp(cyc);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 7'h11; bus.req_size = 4'd8;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("hold%0d_state", k), int'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready}),
          int'({1'b1, 1'b0, 8'hA5, 1'b0}));
    end
    bus.req_valid = 1'b0;
    check_rsp("hold");
    consume();
    sb.push_back('{8'h7F, 1'b0});
    issue(1'b0, 7'h11, 8'h00, 4'd8);
    wait_rsp(cyc);
    check_rsp("after_hold");
    consume();

    // Reset in the first bus cycle
    issue(1'b0, 7'h05, 8'h00, 4'd8);
    chk("rstbus_oe_before", int'(bus.Mout_oe_ram), 1);
    #1 reset = 1'b0;
    #1;
    chk("rstbus_oe_async", int'(bus.Mout_oe_ram), 0);
    chk("rstbus_rsp_valid", int'(bus.rsp_valid), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstbus_req_ready", int'(bus.req_ready), 1);
    chk("rstbus_no_rsp", int'(bus.rsp_valid), 0);

    chk("no_oe_and_we", overlap, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
